program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 194 +++++++++++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Receives a byte stream and writes a program into instruction memory.
// Stream layout: 16-bit big-endian word count N, then N big-endian words.
// The CPU is held in reset until the whole image has been written.
//
// Ports
//   clk        : system clock, all state changes on its rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : stream source presents a byte on in_data
//   in_data    : stream byte
//   in_ready   : loader accepts a byte this cycle (CNT_HI, CNT_LO, DATA)
//   reload     : one-cycle request to start a new load (only honoured in
//                DONE or ERR)
//   imem_we    : instruction memory write strobe (one cycle per word)
//   imem_addr  : instruction memory word address
//   imem_wdata : instruction word
//   cpu_rst    : active-high reset to the CPU
//   load_done  : program loaded, CPU released
//   load_err   : header word count exceeded memory capacity
// -----------------------------------------------------------------------------
module program_loader #(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   input  logic                  reload,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_rst,
   output logic                  load_done,
   output logic                  load_err
);

   typedef enum logic [2:0] {
      CNT_HI = 3'd0,
      CNT_LO = 3'd1,
      DATA   = 3'd2,
      DONE   = 3'd3,
      ERR    = 3'd4
   } state_t;

   // Capacity in words, widened so N = 2^ADDR_WIDTH itself is representable.
   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

   state_t                state_r, state_nxt;
   logic [15:0]           n_r, n_nxt;
   logic [15:0]           n_full_s;
   // Only the first three bytes of a word need storing; the fourth byte is
   // taken straight from in_data when the word is written.
   logic [23:0]           asm_r, asm_nxt;
   logic [1:0]            byte_cnt_r, byte_cnt_nxt;
   // One bit wider than the address so the index can reach N = capacity.
   logic [ADDR_WIDTH:0]   word_idx_r, word_idx_nxt;
   logic                  accept_s;
   logic                  last_word_s;
   logic                  we_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic [31:0]           wdata_nxt;
   logic                  cpu_rst_nxt;
   logic                  done_nxt;
   logic                  err_nxt;
   logic                  ready_s;

   // Byte acceptance decode from the current state.
   always_comb begin
      ready_s = 1'b0;
      case (state_r)
         CNT_HI, CNT_LO, DATA: ready_s = 1'b1;
         default:              ready_s = 1'b0;
      endcase
   end

   assign in_ready = ready_s;
   assign accept_s = in_valid & ready_s;
   assign n_full_s = {n_r[15:8], in_data};

   // True while the word being assembled is the last one of the image.
   assign last_word_s = (({{(16 - ADDR_WIDTH){1'b0}}, word_idx_r} + 17'd1) == {1'b0, n_r});

   // Next-state and datapath update.
   always_comb begin
      state_nxt    = state_r;
      n_nxt        = n_r;
      asm_nxt      = asm_r;
      byte_cnt_nxt = byte_cnt_r;
      word_idx_nxt = word_idx_r;
      we_nxt       = 1'b0;
      addr_nxt     = imem_addr;
      wdata_nxt    = imem_wdata;

      case (state_r)
         CNT_HI: begin
            if (accept_s) begin
               n_nxt     = {in_data, 8'h00};
               state_nxt = CNT_LO;
            end else begin
               state_nxt = CNT_HI;
            end
         end
         CNT_LO: begin
            if (accept_s) begin
               n_nxt        = n_full_s;
               byte_cnt_nxt = 2'd0;
               word_idx_nxt = '0;
               if ({1'b0, n_full_s} > CAPACITY) begin
                  state_nxt = ERR;
               end else if (n_full_s == 16'd0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = DATA;
               end
            end else begin
               state_nxt = CNT_LO;
            end
         end
         DATA: begin
            if (accept_s) begin
               asm_nxt      = {asm_r[15:0], in_data};
               byte_cnt_nxt = byte_cnt_r + 2'd1;
               if (byte_cnt_r == 2'd3) begin
                  we_nxt       = 1'b1;
                  addr_nxt     = word_idx_r[ADDR_WIDTH-1:0];
                  wdata_nxt    = {asm_r, in_data};
                  word_idx_nxt = word_idx_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                  if (last_word_s) begin
                     state_nxt = DONE;
                  end else begin
                     state_nxt = DATA;
                  end
               end else begin
                  state_nxt = DATA;
               end
            end else begin
               state_nxt = DATA;
            end
         end
         DONE, ERR: begin
            if (reload) begin
               state_nxt    = CNT_HI;
               n_nxt        = 16'd0;
               byte_cnt_nxt = 2'd0;
               word_idx_nxt = '0;
            end else begin
               state_nxt = state_r;
            end
         end
         default: begin
            state_nxt = CNT_HI;
         end
      endcase

      // load_done rises one edge after DONE is entered (the final write strobe
      // has then finished); a reload clears it on the same edge it leaves DONE.
      done_nxt    = (state_r == DONE) && (state_nxt == DONE);
      cpu_rst_nxt = ~done_nxt;
      err_nxt     = (state_nxt == ERR);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= CNT_HI;
         n_r        <= 16'd0;
         asm_r      <= 24'd0;
         byte_cnt_r <= 2'd0;
         word_idx_r <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         cpu_rst    <= 1'b1;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         state_r    <= state_nxt;
         n_r        <= n_nxt;
         asm_r      <= asm_nxt;
         byte_cnt_r <= byte_cnt_nxt;
         word_idx_r <= word_idx_nxt;
         imem_we    <= we_nxt;
         imem_addr  <= addr_nxt;
         imem_wdata <= wdata_nxt;
         cpu_rst    <= cpu_rst_nxt;
         load_done  <= done_nxt;
         load_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed bench for program_loader: a table of {inputs, expected outputs}
// records applied one per clock, followed by hand-written sequences for the
// full-capacity image, in_valid gaps and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_program_loader;

   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          reload;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst;
   logic          load_done;
   logic          load_err;

   int n_vec = 0;
   int n_bad = 0;

   program_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [7:0]    d;
      logic          rl;
      logic          rdy;
      logic          we;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
      logic          crst;
      logic          done;
      logic          err;
   } vec_t;

   vec_t vecs[$];

   // Output bundle: {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err}
   function automatic logic [42:0] pack(input logic rdy, input logic we,
                                        input logic [AW-1:0] addr, input logic [31:0] wdata,
                                        input logic crst, input logic done, input logic err);
      return {rdy, we, addr, wdata, crst, done, err};
   endfunction

   function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rl,
                               input logic rdy, input logic we, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input logic crst,
                               input logic done, input logic err);
      vec_t t;
      t.v = v; t.d = d; t.rl = rl; t.rdy = rdy; t.we = we; t.addr = addr;
      t.wdata = wdata; t.crst = crst; t.done = done; t.err = err;
      return t;
   endfunction

   // Present inputs at a falling edge, let one rising edge pass, return at the next falling edge.
   task automatic drive(input logic v, input logic [7:0] d, input logic rl);
      in_valid = v;
      in_data  = d;
      reload   = rl;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      reload   = 1'b0;
   endtask

   task automatic check(input string name, input logic [42:0] exp);
      logic [42:0] act;
      act = {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, load_done, load_err};
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got rdy/we/addr/wdata/crst/done/err = %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] wd;
      logic [7:0]  bi;
      logic [31:0] last_wd;

      // Table: continuous N=2 stream, DONE with in_valid held, N=0, N=65, reload handling.
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h8C, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 6'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 6'd0, 32'h8C01_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h8C, 1'b0, 1'b1, 1'b0, 6'd0, 32'h8C01_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 6'd0, 32'h8C01_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 6'd0, 32'h8C01_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd1, 32'h8C02_0000, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 6'd1, 32'h8C02_0000, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 6'd1, 32'h8C02_0000, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;
      #1;
      check("reset_hold", pack(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_release", pack(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].v, vecs[i].d, vecs[i].rl);
         check($sformatf("vec%0d", i),
               pack(vecs[i].rdy, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    vecs[i].crst, vecs[i].done, vecs[i].err));
      end

      // Full capacity: N = 64 must load every address 0..63.
      drive(1'b1, 8'h00, 1'b0);
      drive(1'b1, 8'h40, 1'b0);
      check("cap64_hdr", pack(1'b1, 1'b0, 6'd1, 32'h8C02_0000, 1'b1, 1'b0, 1'b0));
      last_wd = 32'h0;
      for (int w = 0; w < 64; w++) begin
         bi = 8'(w);
         wd = {bi, bi ^ 8'hA5, ~bi, 8'h5A};
         for (int k = 0; k < 4; k++) begin
            drive(1'b1, wd[31 - 8 * k -: 8], 1'b0);
         end
         check($sformatf("cap64_w%0d", w),
               pack((w == 63) ? 1'b0 : 1'b1, 1'b1, 6'(w), wd, 1'b1, 1'b0, 1'b0));
         last_wd = wd;
      end
      drive(1'b0, 8'h00, 1'b0);
      check("cap64_done", pack(1'b0, 1'b0, 6'd63, last_wd, 1'b0, 1'b1, 1'b0));
      drive(1'b0, 8'h00, 1'b1);

      // N = 1 with three idle cycles before each byte.
      drive(1'b1, 8'h00, 1'b0);
      drive(1'b1, 8'h01, 1'b0);
      wd = 32'h1234_5678;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < 3; g++) begin
            drive(1'b0, 8'hEE, 1'b0);
         end
         check2($sformatf("gap_idle%0d", k), {in_ready, imem_we}, 2'b10);
         drive(1'b1, wd[31 - 8 * k -: 8], 1'b0);
      end
      check("gap_write", pack(1'b0, 1'b1, 6'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b0));
      drive(1'b0, 8'h00, 1'b0);
      check("gap_done", pack(1'b0, 1'b0, 6'd0, 32'h1234_5678, 1'b0, 1'b1, 1'b0));
      drive(1'b0, 8'h00, 1'b1);

      // Reset after two data bytes of an N=3 image, then a fresh N=1 image.
      drive(1'b1, 8'h00, 1'b0);
      drive(1'b1, 8'h03, 1'b0);
      drive(1'b1, 8'hAA, 1'b0);
      drive(1'b1, 8'hBB, 1'b0);
      rst = 1'b1;
      #1;
      check("midload_rst", pack(1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      rst = 1'b0;
      drive(1'b1, 8'h00, 1'b0);
      drive(1'b1, 8'h01, 1'b0);
      drive(1'b1, 8'hDE, 1'b0);
      drive(1'b1, 8'hAD, 1'b0);
      drive(1'b1, 8'hBE, 1'b0);
      check2("replay_no_early_we", {in_ready, imem_we}, 2'b10);
      drive(1'b1, 8'hEF, 1'b0);
      check("replay_write", pack(1'b0, 1'b1, 6'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0));
      drive(1'b1, 8'h55, 1'b0);
      check("replay_done", pack(1'b0, 1'b0, 6'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
